// File: rtl/max_finder_stream.sv
// max_finder_stream
// Streaming extremum finder. It takes a frame of N unsigned WIDTH-bit numbers, one per
// valid/ready handshake, and returns the maximum (mode_min=0) or minimum (mode_min=1)
// together with its position in the frame. The result is zero-extended to OUT_WIDTH.
// When values tie, the earliest position wins.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for element 0 of a frame
//   ACCUM | elements 1..N-1 being accepted and compared against best
//   DONE  | result presented on res_*, input side stalled
module max_finder_stream #(
  parameter int WIDTH     = 4,
  parameter int N         = 4,
  parameter int OUT_WIDTH = 8,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 mode_min,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] res_value,
  output logic [IDX_W-1:0]     res_index,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t             state;
  logic [IDX_W-1:0]   count;
  logic [WIDTH-1:0]   best;
  logic [IDX_W-1:0]   best_idx;
  logic               mode_q;
  logic               take;

  // Strict compare against the running best; ties keep the earlier element.
  assign take = mode_q ? (in_data < best) : (in_data > best);

  // Result is the running best, zero-extended; stable because best only moves outside DONE.
  assign res_value = OUT_WIDTH'(best);
  assign res_index = best_idx;

  // Frame sequencing with registered handshake/status flags.
  // in_ready, busy and res_valid are loaded alongside state so they always match it.
  // count stops at N-1 when entering DONE and is cleared on the way back to IDLE,
  // so it never wraps even when N is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      best      <= '0;
      best_idx  <= '0;
      mode_q    <= 1'b0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      count     <= '0;
      in_ready  <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            best     <= in_data;
            best_idx <= '0;
            mode_q   <= mode_min;
            busy     <= 1'b1;
            if (N == 1) begin
              state     <= DONE;
              count     <= '0;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              state <= ACCUM;
              count <= IDX_W'(1);
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (take) begin
              best     <= in_data;
              best_idx <= count;
            end
            if (count == LAST) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          in_ready  <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_max_finder_stream.sv
// tb_max_finder_stream
// Randomized bench for max_finder_stream: a default instance (4b x 4, 8b out), an N=1
// instance and a wide instance (8b x 5, 12b out). Expected results come from a queue
// model using min/max and first-index search over the whole frame.
module tb_max_finder_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic       clr0 = 0, mode0 = 0, v0 = 0, rr0 = 0;
  logic [3:0] d0 = '0;
  logic       rdy0, rv0, busy0;
  logic [7:0] rval0;
  logic [1:0] ri0;

  // N=1 instance
  logic       clr1 = 0, mode1 = 0, v1 = 0, rr1 = 0;
  logic [3:0] d1 = '0;
  logic       rdy1, rv1, busy1;
  logic [7:0] rval1;
  logic [0:0] ri1;

  // wide instance
  logic        clr2 = 0, mode2 = 0, v2 = 0, rr2 = 0;
  logic [7:0]  d2 = '0;
  logic        rdy2, rv2, busy2;
  logic [11:0] rval2;
  logic [2:0]  ri2;

  max_finder_stream #(.WIDTH(4), .N(4), .OUT_WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .mode_min(mode0), .in_data(d0),
    .in_valid(v0), .in_ready(rdy0), .res_value(rval0), .res_index(ri0),
    .res_valid(rv0), .res_ready(rr0), .busy(busy0));

  max_finder_stream #(.WIDTH(4), .N(1), .OUT_WIDTH(8)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .mode_min(mode1), .in_data(d1),
    .in_valid(v1), .in_ready(rdy1), .res_value(rval1), .res_index(ri1),
    .res_valid(rv1), .res_ready(rr1), .busy(busy1));

  max_finder_stream #(.WIDTH(8), .N(5), .OUT_WIDTH(12)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(clr2), .mode_min(mode2), .in_data(d2),
    .in_valid(v2), .in_ready(rdy2), .res_value(rval2), .res_index(ri2),
    .res_valid(rv2), .res_ready(rr2), .busy(busy2));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: extremum of the whole frame, position of its first occurrence.
  function automatic void ref_ext(input int q[$], input bit mn, output int v, output int ix);
    int m[$];
    int f[$];
    m  = mn ? q.min() : q.max();
    v  = m[0];
    f  = q.find_first_index(item) with (item == v);
    ix = f[0];
  endfunction

  // Drives one frame into u0 starting at a negedge. lat = cycle (element 0's cycle is 1)
  // in which res_valid is first seen; -1 if res_valid was seen before the last element.
  task automatic send_frame0(input int q[$], input bit mn, input bit gaps,
                             output int lat, output bit tmo);
    int c;
    int t;
    bit early;
    c = 0; early = 0; tmo = 0;
    foreach (q[i]) begin
      if (gaps && i > 0) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          v0 = 0; d0 = 4'($urandom); mode0 = 1'($urandom);
          @(negedge clk); c++;
          if (rv0) early = 1;
        end
      end
      v0 = 1; d0 = 4'(q[i]);
      mode0 = (i == 0) ? mn : 1'($urandom);
      if (c == 0) c = 1;
      @(negedge clk);
      if (i != q.size() - 1) begin
        c++;
        if (rv0) early = 1;
      end
    end
    c++;
    v0 = 0; d0 = 4'($urandom); mode0 = 1'($urandom);
    t = 0;
    while (!rv0 && t < 20) begin
      @(negedge clk); c++; t++;
    end
    if (!rv0) tmo = 1;
    lat = early ? -1 : c;
  endtask

  task automatic handshake0();
    rr0 = 1;
    @(negedge clk);
    rr0 = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (rdy0 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", rdy0); else n_pass++;
    n_checks++; if (rv0 !== 1'b0) $display("FAIL reset_res_valid got %b want 0", rv0); else n_pass++;
    n_checks++; if (rval0 !== 8'h00) $display("FAIL reset_res_value got %h want 00", rval0); else n_pass++;
    n_checks++; if (ri0 !== 2'd0) $display("FAIL reset_res_index got %0d want 0", ri0); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy0); else n_pass++;
  endtask

  task automatic test_max_back_to_back();
    int q[$];
    int ev, ei, lat;
    bit tmo;
    q = {3, 9, 2, 7};
    ref_ext(q, 0, ev, ei);
    send_frame0(q, 0, 0, lat, tmo);
    n_checks++; if (tmo || lat != 5) $display("FAIL b2b_latency got %0d (timeout %0d) want 5", lat, tmo); else n_pass++;
    n_checks++; if (rval0 !== 8'(ev)) $display("FAIL b2b_value got %h want %h", rval0, 8'(ev)); else n_pass++;
    n_checks++; if (ri0 !== 2'(ei)) $display("FAIL b2b_index got %0d want %0d", ri0, ei); else n_pass++;
    handshake0();
    for (int f = 0; f < 6; f++) begin
      bit mn;
      q = {};
      for (int k = 0; k < 4; k++) q.push_back($urandom_range(0, 15));
      mn = 1'($urandom);
      ref_ext(q, mn, ev, ei);
      send_frame0(q, mn, 0, lat, tmo);
      n_checks++;
      if (tmo || lat != 5 || rval0 !== 8'(ev) || ri0 !== 2'(ei))
        $display("FAIL rand_frame%0d got val=%h idx=%0d lat=%0d want val=%h idx=%0d lat=5",
                 f, rval0, ri0, lat, 8'(ev), ei);
      else n_pass++;
      handshake0();
    end
  endtask

  task automatic test_ties();
    int q[$];
    int ev, ei, lat;
    bit tmo;
    q = {5, 10, 10, 1};
    ref_ext(q, 0, ev, ei);
    send_frame0(q, 0, 0, lat, tmo);
    n_checks++; if (tmo || rval0 !== 8'(ev)) $display("FAIL tie_value got %h want %h", rval0, 8'(ev)); else n_pass++;
    n_checks++; if (ri0 !== 2'(ei)) $display("FAIL tie_index got %0d want %0d", ri0, ei); else n_pass++;
    handshake0();
    q = {4, 4, 4, 4};
    ref_ext(q, 1'($urandom), ev, ei);
    send_frame0(q, 0, 0, lat, tmo);
    n_checks++; if (tmo || rval0 !== 8'h04) $display("FAIL alleq_value got %h want 04", rval0); else n_pass++;
    n_checks++; if (ri0 !== 2'(ei)) $display("FAIL alleq_index got %0d want %0d", ri0, ei); else n_pass++;
    handshake0();
  endtask

  task automatic test_mode_latch();
    int q[$];
    int ev, ei;
    int t;
    q = {3, 9, 2, 7};
    ref_ext(q, 1, ev, ei);
    foreach (q[i]) begin
      v0 = 1; d0 = 4'(q[i]);
      mode0 = (i < 2) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    v0 = 0;
    t = 0;
    while (!rv0 && t < 20) begin @(negedge clk); t++; end
    n_checks++; if (!rv0 || rval0 !== 8'(ev)) $display("FAIL mode_latch_value got %h want %h", rval0, 8'(ev)); else n_pass++;
    n_checks++; if (ri0 !== 2'(ei)) $display("FAIL mode_latch_index got %0d want %0d", ri0, ei); else n_pass++;
    handshake0();
  endtask

  task automatic test_gaps_stall();
    int q[$];
    int ev, ei, lat;
    bit tmo, mn;
    q = {};
    for (int k = 0; k < 4; k++) q.push_back($urandom_range(0, 15));
    mn = 1'($urandom);
    ref_ext(q, mn, ev, ei);
    send_frame0(q, mn, 1, lat, tmo);
    n_checks++; if (tmo || lat < 5) $display("FAIL gap_latency got %0d (timeout %0d) want >=5", lat, tmo); else n_pass++;
    n_checks++; if (rval0 !== 8'(ev) || ri0 !== 2'(ei))
      $display("FAIL gap_result got val=%h idx=%0d want val=%h idx=%0d", rval0, ri0, 8'(ev), ei); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      v0 = 1'($urandom); d0 = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if (rv0 !== 1'b1 || rdy0 !== 1'b0 || busy0 !== 1'b1 || rval0 !== 8'(ev) || ri0 !== 2'(ei))
        $display("FAIL stall_hold%0d got rv=%b rdy=%b busy=%b val=%h idx=%0d want rv=1 rdy=0 busy=1 val=%h idx=%0d",
                 k, rv0, rdy0, busy0, rval0, ri0, 8'(ev), ei);
      else n_pass++;
    end
    v0 = 0;
    handshake0();
    n_checks++; if (rv0 !== 1'b0) $display("FAIL hs_res_valid got %b want 0", rv0); else n_pass++;
    n_checks++; if (rdy0 !== 1'b1) $display("FAIL hs_in_ready got %b want 1", rdy0); else n_pass++;
    n_checks++; if (busy0 !== 1'b0) $display("FAIL hs_busy got %b want 0", busy0); else n_pass++;
    q = {15, 0, 0, 0};
    ref_ext(q, 0, ev, ei);
    send_frame0(q, 0, 0, lat, tmo);
    n_checks++; if (tmo || rval0 !== 8'(ev)) $display("FAIL second_value got %h want %h", rval0, 8'(ev)); else n_pass++;
    n_checks++; if (ri0 !== 2'(ei)) $display("FAIL second_index got %0d want %0d", ri0, ei); else n_pass++;
    handshake0();
  endtask

  task automatic test_reset_midframe();
    int q[$];
    int ev, ei, lat;
    bit tmo;
    v0 = 1; d0 = 4'd12; mode0 = 0; @(negedge clk);
    v0 = 1; d0 = 4'd13; @(negedge clk);
    v0 = 0;
    rst_n = 0;
    #1;
    n_checks++;
    if (rdy0 !== 1'b1 || rv0 !== 1'b0 || busy0 !== 1'b0 || rval0 !== 8'h00 || ri0 !== 2'd0)
      $display("FAIL midreset_outputs got rdy=%b rv=%b busy=%b val=%h idx=%0d want 1 0 0 00 0",
               rdy0, rv0, busy0, rval0, ri0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (rv0 !== 1'b0 || busy0 !== 1'b0) $display("FAIL midreset_idle%0d got rv=%b busy=%b want 0 0", k, rv0, busy0); else n_pass++;
    end
    q = {1, 2, 3, 4};
    ref_ext(q, 0, ev, ei);
    send_frame0(q, 0, 0, lat, tmo);
    n_checks++; if (tmo || lat != 5 || rval0 !== 8'(ev) || ri0 !== 2'(ei))
      $display("FAIL after_reset got val=%h idx=%0d lat=%0d want val=%h idx=%0d lat=5", rval0, ri0, lat, 8'(ev), ei); else n_pass++;
    handshake0();
  endtask

  task automatic test_clr();
    int q[$];
    int ev, ei, lat;
    bit tmo;
    for (int k = 0; k < 3; k++) begin
      v0 = 1; d0 = 4'(14 - k); mode0 = 0; @(negedge clk);
    end
    // clr together with a valid element: the abort must win
    clr0 = 1; v0 = 1; d0 = 4'd15;
    @(negedge clk);
    clr0 = 0; v0 = 0;
    n_checks++; if (busy0 !== 1'b0 || rv0 !== 1'b0 || rdy0 !== 1'b1)
      $display("FAIL clr_idle got busy=%b rv=%b rdy=%b want 0 0 1", busy0, rv0, rdy0); else n_pass++;
    q = {1, 2, 3, 4};
    ref_ext(q, 0, ev, ei);
    send_frame0(q, 0, 0, lat, tmo);
    n_checks++; if (tmo || lat != 5 || rval0 !== 8'(ev) || ri0 !== 2'(ei))
      $display("FAIL after_clr got val=%h idx=%0d lat=%0d want val=%h idx=%0d lat=5", rval0, ri0, lat, 8'(ev), ei); else n_pass++;
    // clr while a result waits, together with res_ready
    clr0 = 1; rr0 = 1;
    @(negedge clk);
    clr0 = 0; rr0 = 0;
    n_checks++; if (rv0 !== 1'b0 || busy0 !== 1'b0 || rdy0 !== 1'b1)
      $display("FAIL clr_done got rv=%b busy=%b rdy=%b want 0 0 1", rv0, busy0, rdy0); else n_pass++;
  endtask

  task automatic test_n1();
    n_checks++; if (rdy1 !== 1'b1 || rv1 !== 1'b0) $display("FAIL n1_idle got rdy=%b rv=%b want 1 0", rdy1, rv1); else n_pass++;
    v1 = 1; d1 = 4'd6; mode1 = 1'($urandom);
    @(negedge clk);
    v1 = 0;
    n_checks++; if (rv1 !== 1'b1 || rdy1 !== 1'b0) $display("FAIL n1_latency got rv=%b rdy=%b want 1 0", rv1, rdy1); else n_pass++;
    n_checks++; if (rval1 !== 8'h06 || ri1 !== 1'b0) $display("FAIL n1_result got val=%h idx=%0d want 06 0", rval1, ri1); else n_pass++;
    rr1 = 1; @(negedge clk); rr1 = 0;
    n_checks++; if (rv1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL n1_handshake got rv=%b busy=%b want 0 0", rv1, busy1); else n_pass++;
  endtask

  task automatic test_wide();
    int q[$];
    int ev, ei;
    for (int f = 0; f < 3; f++) begin
      bit mn;
      if (f == 0) begin
        q = {0, 255, 255, 1, 254};
        mn = 0;
      end else begin
        q = {};
        for (int k = 0; k < 5; k++) q.push_back($urandom_range(0, 255));
        mn = 1'($urandom);
      end
      ref_ext(q, mn, ev, ei);
      foreach (q[i]) begin
        v2 = 1; d2 = 8'(q[i]); mode2 = (i == 0) ? mn : 1'($urandom);
        @(negedge clk);
      end
      v2 = 0;
      n_checks++;
      if (rv2 !== 1'b1 || rval2 !== 12'(ev) || ri2 !== 3'(ei))
        $display("FAIL wide_frame%0d got rv=%b val=%h idx=%0d want rv=1 val=%h idx=%0d",
                 f, rv2, rval2, ri2, 12'(ev), ei);
      else n_pass++;
      rr2 = 1; @(negedge clk); rr2 = 0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_max_back_to_back();
    test_ties();
    test_mode_latch();
    test_gaps_stall();
    test_reset_midframe();
    test_clr();
    test_n1();
    test_wide();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
